instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/picomips_pkg.sv | 7 +
 rtl/pc_next.sv | 14 +
 rtl/instr_fetch.sv | 54 +++++
 tb/tb_instr_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// picomips_pkg: shared widths, fetch FSM states and next-address selector codes
package picomips_pkg;
    localparam int PSIZE_DEFAULT = 6;
    localparam int ISIZE_DEFAULT = 16;
    typedef enum logic [1:0] {FILL, RUN, FLUSH} fetch_state_t;
    typedef enum logic [1:0] {SEL_ZERO, SEL_HOLD, SEL_INC, SEL_BRANCH} next_sel_t;
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next fetch address (zero, hold, increment or relative branch target)
module pc_next import picomips_pkg::*; #(
    parameter int PSIZE = PSIZE_DEFAULT
) (
    input  next_sel_t        sel,
    input  logic [PSIZE-1:0] ia,
    input  logic [PSIZE-1:0] pc,
    input  logic [PSIZE-1:0] offset,
    output logic [PSIZE-1:0] next
);
    always_comb next = sel == SEL_ZERO ? '0 :
                       sel == SEL_HOLD ? ia :
                       sel == SEL_INC  ? ia + PSIZE'(1) : pc + offset;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding a synchronous program memory, with stall and one-bubble relative branches
module instr_fetch import picomips_pkg::*; #(
    parameter int PSIZE = PSIZE_DEFAULT,
    parameter int ISIZE = ISIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             n_reset,
    output logic [PSIZE-1:0] imem_addr,
    input  logic [ISIZE-1:0] imem_rdata,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [PSIZE-1:0] branch_offset,
    output logic [ISIZE-1:0] instr,
    output logic             instr_valid,
    output logic [PSIZE-1:0] pc_out
);
    fetch_state_t     state, state_nx;
    next_sel_t        sel;
    logic [PSIZE-1:0] ia;
    logic             br, load;

    // reset forces FILL asynchronously, so imem_addr reads 0 while n_reset is low
    always_comb begin
        br       = state == RUN && branch_taken && !stall && instr_valid;
        load     = state != FILL && !stall && !br;
        sel      = state == FILL ? SEL_ZERO : stall ? SEL_HOLD : br ? SEL_BRANCH : SEL_INC;
        state_nx = state == FILL ? RUN : stall ? state : br ? FLUSH : RUN;
    end

    pc_next #(.PSIZE(PSIZE)) u_pc_next (
        .sel    (sel),
        .ia     (ia),
        .pc     (pc_out),
        .offset (branch_offset),
        .next   (imem_addr)
    );

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            state       <= FILL;
            ia          <= '0;
            pc_out      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            ia          <= imem_addr;
            instr_valid <= (stall && state != FILL) ? instr_valid : load;
            if (load) begin
                instr  <= imem_rdata;
                pc_out <= ia;
            end
        end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven, directed and randomized model-checked bench for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [5:0]  branch_offset = '0;
    logic [15:0] instr;
    logic        instr_valid;
    logic [5:0]  pc_out;
    int passed = 0;
    int total  = 0;

    instr_fetch dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= 16'hA000 + 16'(imem_addr);

    typedef struct {
        logic       st;
        logic       bt;
        logic [5:0] off;
        logic       ev;
        logic [5:0] epc;
        logic [5:0] eaddr;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_offset = '0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    // reference model: what the decoder sees, in terms of program order
    logic       m_valid, m_fill;
    logic [5:0] m_pc, m_nxt;
    logic [15:0] m_instr;

    task automatic m_reset();
        m_valid = 1'b0; m_fill = 1'b1; m_pc = '0; m_nxt = '0; m_instr = '0;
    endtask

    task automatic m_step(input logic st, input logic bt, input logic [5:0] off);
        if (m_fill) m_fill = 1'b0;
        else if (st) ;
        else if (bt && m_valid) begin
            m_valid = 1'b0;
            m_nxt = m_pc + off;
        end else begin
            m_valid = 1'b1;
            m_pc = m_nxt;
            m_nxt = m_pc + 6'd1;
            m_instr = 16'hA000 + 16'(m_pc);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 6'h00, 1'b0, 6'd0,  6'd0};
        tbl[1]  = '{1'b0, 1'b0, 6'h00, 1'b0, 6'd0,  6'd1};
        tbl[2]  = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd0,  6'd2};
        tbl[3]  = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd1,  6'd3};
        tbl[4]  = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd2,  6'd4};
        tbl[5]  = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd3,  6'd5};
        tbl[6]  = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd4,  6'd6};
        tbl[7]  = '{1'b1, 1'b0, 6'h00, 1'b1, 6'd5,  6'd6};
        tbl[8]  = '{1'b1, 1'b0, 6'h00, 1'b1, 6'd5,  6'd6};
        tbl[9]  = '{1'b1, 1'b0, 6'h00, 1'b1, 6'd5,  6'd6};
        tbl[10] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd5,  6'd7};
        tbl[11] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd6,  6'd8};
        tbl[12] = '{1'b1, 1'b1, 6'h05, 1'b1, 6'd7,  6'd8};
        tbl[13] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd7,  6'd9};
        tbl[14] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd8,  6'd10};
        tbl[15] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd9,  6'd11};
        tbl[16] = '{1'b0, 1'b1, 6'h3C, 1'b1, 6'd10, 6'd6};
        tbl[17] = '{1'b0, 1'b1, 6'h1F, 1'b0, 6'd10, 6'd7};
        tbl[18] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd6,  6'd8};
        tbl[19] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'd7,  6'd9};

        #1;
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_pc", 32'(pc_out), 32'd0);
        chk("reset_instr", 32'(instr), 32'd0);
        chk("reset_addr", 32'(imem_addr), 32'd0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            stall = tbl[i].st;
            branch_taken = tbl[i].bt;
            branch_offset = tbl[i].off;
            #1;
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_pc", i), 32'(pc_out), 32'(tbl[i].epc));
            chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].eaddr));
            if (tbl[i].ev) chk($sformatf("tbl%0d_instr", i), 32'(instr), 32'(16'hA000 + 16'(tbl[i].epc)));
            @(negedge clk);
        end

        do_reset();
        repeat (64) @(negedge clk);
        #1;
        chk("wrap_pc62", 32'(pc_out), 32'd62);
        chk("wrap_addr0", 32'(imem_addr), 32'd0);
        @(negedge clk); #1;
        chk("wrap_pc63", 32'(pc_out), 32'd63);
        chk("wrap_instr63", 32'(instr), 32'h0000A03F);
        chk("wrap_addr1", 32'(imem_addr), 32'd1);
        @(negedge clk);
        branch_taken = 1'b1;
        branch_offset = 6'd2;
        #1;
        chk("wrap_pc0", 32'(pc_out), 32'd0);
        chk("wrap_instr0", 32'(instr), 32'h0000A000);
        chk("wrap_br_addr", 32'(imem_addr), 32'd2);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        chk("wrap_bubble", 32'(instr_valid), 32'd0);
        @(negedge clk); #1;
        chk("wrap_tgt_valid", 32'(instr_valid), 32'd1);
        chk("wrap_tgt_pc", 32'(pc_out), 32'd2);
        chk("wrap_tgt_instr", 32'(instr), 32'h0000A002);

        branch_taken = 1'b1;
        branch_offset = 6'd3;
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        chk("flush_bubble", 32'(instr_valid), 32'd0);
        #1 n_reset = 1'b0;
        #1;
        chk("flush_rst_valid", 32'(instr_valid), 32'd0);
        chk("flush_rst_pc", 32'(pc_out), 32'd0);
        chk("flush_rst_instr", 32'(instr), 32'd0);
        chk("flush_rst_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk); #1;
        chk("restart_edge1", 32'(instr_valid), 32'd0);
        @(negedge clk); #1;
        chk("restart_valid", 32'(instr_valid), 32'd1);
        chk("restart_pc", 32'(pc_out), 32'd0);
        chk("restart_instr", 32'(instr), 32'h0000A000);

        do_reset();
        m_reset();
        for (int c = 0; c < 500; c++) begin
            #1;
            chk($sformatf("rnd%0d_valid", c), 32'(instr_valid), 32'(m_valid));
            chk($sformatf("rnd%0d_pc", c), 32'(pc_out), 32'(m_pc));
            chk($sformatf("rnd%0d_instr", c), 32'(instr), 32'(m_instr));
            stall = ($urandom_range(0, 99) < 25);
            branch_taken = ($urandom_range(0, 99) < 25);
            branch_offset = 6'($urandom_range(0, 63));
            n_reset = ($urandom_range(0, 99) != 0);
            if (!n_reset) m_reset();
            else m_step(stall, branch_taken, branch_offset);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
